// File: rtl/optical_switch_driver.sv
// rtl/optical_switch_driver.sv - sequences blank/guard/apply/settle reconfiguration of four optical switch elements
module optical_switch_driver #(
  parameter int P_GUARD_CYCLES  = 4,
  parameter int P_SETTLE_CYCLES = 16,
  parameter int P_CNT_W         = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_switch_grant,
  input  logic       i_grant_valid,
  output logic [3:0] o_sw_ctrl,
  output logic       o_sw_blank,
  output logic       o_sw_ready,
  output logic       o_reconfig_done,
  output logic       o_overwrite
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GUARD  = 2'd1;
  localparam logic [1:0] ST_APPLY  = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  localparam logic [P_CNT_W-1:0] GUARD_LOAD  = P_CNT_W'(P_GUARD_CYCLES - 1);
  localparam logic [P_CNT_W-1:0] SETTLE_LOAD = P_CNT_W'(P_SETTLE_CYCLES - 1);
  localparam logic [P_CNT_W-1:0] CNT_ONE     = P_CNT_W'(1);

  logic [1:0]         state;
  logic [P_CNT_W-1:0] cnt;
  logic [3:0]         target;
  logic [3:0]         pend;
  logic               pend_full;
  logic               configured;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      target          <= 4'b0000;
      pend            <= 4'b0000;
      pend_full       <= 1'b0;
      configured      <= 1'b0;
      o_sw_ctrl       <= 4'b0000;
      o_sw_blank      <= 1'b1;
      o_sw_ready      <= 1'b0;
      o_reconfig_done <= 1'b0;
      o_overwrite     <= 1'b0;
    end else begin
      o_reconfig_done <= 1'b0;
      o_overwrite     <= 1'b0;

      // Any grant arriving mid-reconfiguration parks in the single pending slot.
      if (state != ST_IDLE && i_grant_valid) begin
        pend        <= i_switch_grant;
        pend_full   <= 1'b1;
        o_overwrite <= pend_full;
      end

      case (state)
        ST_IDLE: begin
          if (i_grant_valid) begin
            if (configured && (i_switch_grant == o_sw_ctrl)) begin
              o_reconfig_done <= 1'b1;
            end else begin
              target     <= i_switch_grant;
              state      <= ST_GUARD;
              o_sw_blank <= 1'b1;
              o_sw_ready <= 1'b0;
              cnt        <= GUARD_LOAD;
            end
          end
        end

        ST_GUARD: begin
          if (cnt == '0) begin
            o_sw_ctrl <= target;
            state     <= ST_APPLY;
            cnt       <= SETTLE_LOAD;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        // The APPLY cycle is the first settle cycle after the element drive changed.
        default: begin
          if (cnt == '0) begin
            o_reconfig_done <= 1'b1;
            configured      <= 1'b1;
            if (i_grant_valid) begin
              target    <= i_switch_grant;
              pend_full <= 1'b0;
              state     <= ST_GUARD;
              cnt       <= GUARD_LOAD;
            end else if (pend_full) begin
              target    <= pend;
              pend_full <= 1'b0;
              state     <= ST_GUARD;
              cnt       <= GUARD_LOAD;
            end else begin
              state      <= ST_IDLE;
              o_sw_blank <= 1'b0;
              o_sw_ready <= 1'b1;
            end
          end else begin
            cnt   <= cnt - CNT_ONE;
            state <= ST_SETTLE;
          end
        end
      endcase
    end
  end

endmodule
